// File: rtl/async_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO and its write-side/read-side arbiters.
package async_fifo_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int N_MAX     = 8;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_t;

  // Round-robin winner: first valid index after 'last', wrapping modulo n.
  function automatic logic [2:0] next_rr(input logic [N_MAX-1:0] valid,
                                         input logic [2:0]       last,
                                         input int               n);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_MAX; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !found && valid[idx]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/async_fifo_wr_arbiter_rr.sv
// Combinational rotate-priority encoder; shared by the write- and read-side arbiters.
module rr_arbiter
  import async_fifo_pkg::*;
#(
  parameter int N  = 3,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [GW-1:0] i_last,
  output logic [GW-1:0] o_winner,
  output logic          o_any
);

  logic [N_MAX-1:0] w_valid_ext;
  logic [2:0]       w_win;

  assign w_valid_ext = N_MAX'(i_valid);
  assign w_win       = next_rr(w_valid_ext, 3'(i_last), N);
  assign o_winner    = GW'(w_win);
  assign o_any       = |i_valid;

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among N valid/ready requesters.
module async_fifo_wr_arbiter
  import async_fifo_pkg::*;
#(
  parameter int N         = 3,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int BURST_MAX = 4
) (
  input  logic                   wr_clk,
  input  logic                   reset,
  input  logic [N-1:0]           req_valid,
  input  logic [N*WIDTH-1:0]     req_data,
  output logic [N-1:0]           req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_write_en,
  output logic [WIDTH-1:0]       fifo_write_data,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   busy
);

  localparam int GW = $clog2(N);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);

  arb_state_t    r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last;
  logic [BW-1:0] r_beat;

  logic [GW-1:0]    w_winner;
  logic             w_any;
  logic             w_valid_g;
  logic [WIDTH-1:0] w_data_g;
  logic             w_in_burst;

  rr_arbiter #(.N(N), .GW(GW)) u_rr (
    .i_valid  (req_valid),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_in_burst = (r_state == BURST);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_valid_g = 1'b0;
    w_data_g  = '0;
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant == GW'(i)) begin
        w_valid_g    = req_valid[i];
        w_data_g     = req_data[i*WIDTH +: WIDTH];
        req_ready[i] = w_in_burst && !fifo_full;
      end
    end
  end

  // Full is used combinationally so a write resumes on the very cycle full drops.
  assign fifo_write_en   = w_in_burst && w_valid_g && !fifo_full;
  assign fifo_write_data = w_in_burst ? w_data_g : '0;
  assign grant_id        = r_grant;
  assign busy            = w_in_burst;

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge wr_clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= GW'(N - 1);
      r_beat  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_winner;
            r_last  <= w_winner;
            r_beat  <= '0;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (!w_valid_g) begin
            r_state <= IDLE;
          end else if (!fifo_full) begin
            if (r_beat == BEAT_LAST) begin
              r_state <= IDLE;
              r_beat  <= '0;
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Self-checking bench: transaction-level arbiter model plus a FIFO/requester environment.
module tb_async_fifo_wr_arbiter;
  import async_fifo_pkg::*;

  localparam int N         = 3;
  localparam int WIDTH     = 8;
  localparam int BURST_MAX = 4;
  localparam int DEPTH     = 4;
  localparam int GW        = $clog2(N);

  typedef logic [7:0] byte_q_t [$];

  logic                 wr_clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req_valid;
  logic [N*WIDTH-1:0]   req_data;
  logic [N-1:0]         req_ready;
  logic                 fifo_full;
  logic                 fifo_write_en;
  logic [WIDTH-1:0]     fifo_write_data;
  logic [GW-1:0]        grant_id;
  logic                 busy;

  async_fifo_wr_arbiter #(.N(N), .WIDTH(WIDTH), .BURST_MAX(BURST_MAX)) dut (
    .wr_clk          (wr_clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_pass   = 0;

  byte_q_t src [N];
  byte_q_t fq;
  byte_q_t rd_log;
  byte_q_t grant_log;
  byte_q_t exp_q;
  logic    rd_en   = 1'b0;
  logic    rst_drv = 1'b0;
  logic    prev_busy = 1'b0;

  // Model: who owns the port, how many beats it has moved, who was granted last.
  bit m_known = 1'b0;
  bit m_busy;
  int m_gid, m_last, m_beats;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_q(input string name, input byte_q_t got, input byte_q_t exp);
    check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check(name, (i < got.size()) ? 32'(got[i]) : 32'hxxxx_xxxx, 32'(exp[i]));
  endtask

  function automatic logic [7:0] data_of(input int i);
    return req_data[i*WIDTH +: WIDTH];
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]               = (src[i].size() > 0);
      req_data[i*WIDTH +: WIDTH] = (src[i].size() > 0) ? src[i][0] : 8'h00;
    end
    fifo_full = (fq.size() >= DEPTH);
    reset     = rst_drv;
  endtask

  task automatic model_update();
    bit found;
    int idx;
    if (reset === 1'b0) begin
      m_known = 1'b1; m_busy = 1'b0; m_gid = 0; m_last = N - 1; m_beats = 0;
    end else if (m_known) begin
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!found && req_valid[idx]) begin
            found = 1'b1; m_gid = idx;
          end
        end
        if (found) begin
          m_busy = 1'b1; m_last = m_gid; m_beats = 0;
        end
      end else if (!req_valid[m_gid]) begin
        m_busy = 1'b0;
      end else if (!fifo_full) begin
        m_beats++;
        if (m_beats == BURST_MAX) m_busy = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    logic         e_we;
    logic [N-1:0] e_ready;
    logic [7:0]   e_data;
    logic [N-1:0] xfer;
    logic         wr, rd;
    logic [7:0]   wd;
    #2;
    if (m_known) begin
      e_ready = (m_busy && !fifo_full) ? N'(1 << m_gid) : '0;
      e_we    = m_busy && req_valid[m_gid] && !fifo_full;
      e_data  = m_busy ? data_of(m_gid) : 8'h00;
      check("write_en",   32'(fifo_write_en),   32'(e_we));
      check("req_ready",  32'(req_ready),       32'(e_ready));
      check("write_data", 32'(fifo_write_data), 32'(e_data));
      check("grant_id",   32'(grant_id),        32'(m_gid));
      check("busy",       32'(busy),            32'(m_busy));
    end
    if (busy === 1'b1 && prev_busy !== 1'b1) grant_log.push_back(8'(grant_id));
    prev_busy = busy;
    xfer = req_valid & req_ready;
    wr   = fifo_write_en;
    wd   = fifo_write_data;
    rd   = rd_en && (fq.size() > 0);
    @(posedge wr_clk);
    model_update();
    #1;
    for (int i = 0; i < N; i++)
      if (xfer[i] === 1'b1 && src[i].size() > 0) void'(src[i].pop_front());
    if (rd) rd_log.push_back(fq.pop_front());
    if (wr === 1'b1) fq.push_back(wd);
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      cycle();
      n++;
      done = (src[0].size() == 0) && (src[1].size() == 0) && (src[2].size() == 0) &&
             (fq.size() == 0) && (busy === 1'b0);
    end
    check("drain_in_budget", 32'(done), 32'd1);
  endtask

  task automatic reset_pulse();
    rst_drv = 1'b0; drive(); cycle();
    rst_drv = 1'b1; drive();
    rd_log.delete(); grant_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive();
    // Reset held two cycles, then idle with nothing valid.
    cycle(); cycle();
    rst_drv = 1'b1; drive();
    repeat (3) cycle();
    #1;
    check("idle_grant", 32'(grant_id), 32'd0);
    check("idle_busy",  32'(busy), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd0);
    check("idle_we",    32'(fifo_write_en), 32'd0);

    // Single requester, six beats: burst of four, arbitration gap, burst of two.
    rd_en  = 1'b1;
    src[1] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    drive();
    run_until_idle(60);
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    check_q("single_order", rd_log, exp_q);
    exp_q = '{8'd1, 8'd1};
    check_q("single_grants", grant_log, exp_q);

    // Three requesters contending continuously.
    reset_pulse();
    src[0] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    src[1] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
    src[2] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
    drive();
    run_until_idle(200);
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
              8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
              8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
    check_q("contend_order", rd_log, exp_q);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
    check_q("contend_grants", grant_log, exp_q);

    // Full backpressure: no reads, four writes fill the FIFO, grant is held.
    reset_pulse();
    rd_en  = 1'b0;
    src[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    drive();
    repeat (14) cycle();
    #1;
    check("full_count", 32'(fq.size()), 32'd4);
    check("full_busy",  32'(busy), 32'd1);
    check("full_grant", 32'(grant_id), 32'd0);
    check("full_ready", 32'(req_ready), 32'd0);
    check("full_we",    32'(fifo_write_en), 32'd0);
    rd_en = 1'b1;
    run_until_idle(60);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    check_q("full_order", rd_log, exp_q);

    // Valid drop mid-burst: requester 2 sends two beats, pending requester 0 follows.
    reset_pulse();
    src[2] = '{8'h21, 8'h22};
    drive();
    cycle();
    src[0] = '{8'h31, 8'h32};
    drive();
    run_until_idle(60);
    exp_q = '{8'h21, 8'h22, 8'h31, 8'h32};
    check_q("drop_order", rd_log, exp_q);
    exp_q = '{8'd2, 8'd0};
    check_q("drop_grants", grant_log, exp_q);

    // Reset during beat 2 of requester 1; requester 0 wins first afterwards.
    reset_pulse();
    src[1] = '{8'h41, 8'h42, 8'h43, 8'h44};
    drive();
    cycle();
    cycle();
    rst_drv = 1'b0;
    src[0]  = '{8'h51, 8'h52};
    drive();
    cycle();
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_we",   32'(fifo_write_en), 32'd0);
    rst_drv = 1'b1;
    drive();
    run_until_idle(60);
    exp_q = '{8'h41, 8'h42, 8'h51, 8'h52, 8'h43, 8'h44};
    check_q("rst_order", rd_log, exp_q);
    exp_q = '{8'd1, 8'd0, 8'd1};
    check_q("rst_grants", grant_log, exp_q);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
